bolme_birimi: RTL and testbench

BOLME_BIRIMI -- requirements
Module: bolme_birimi

---
 rtl/bolme_birimi.sv | 149 ++++++++++++++
 tb/tb_bolme_birimi.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/bolme_birimi.sv
// Restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional macro BOLME_ERKEN_CIKIS_EN: zero-divisor/overflow cases bypass the iteration.
module bolme_birimi #(
  parameter int BIT = 32
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  input  logic           basla_i,
  input  logic [1:0]     islem_i,
  input  logic [BIT-1:0] deger1_i,
  input  logic [BIT-1:0] deger2_i,
  input  logic           iptal_i,
  output logic [BIT-1:0] sonuc_o,
  output logic           gecerli_o,
  output logic           mesgul_o
);

  localparam int CW = $clog2(BIT + 1);

  typedef enum logic [1:0] {BOSTA, BOL, DUZELT} durum_t;

  durum_t         durum_q, durum_d;
  logic [1:0]     islem_q, islem_d;
  logic [BIT-1:0] bolum_q, bolum_d;
  logic [BIT:0]   kalan_q, kalan_d;
  logic [BIT-1:0] bolen_q, bolen_d;
  logic [BIT-1:0] ham_q, ham_d;
  logic           neg_b_q, neg_b_d;
  logic           neg_k_q, neg_k_d;
  logic           sifir_q, sifir_d;
  logic           tasma_q, tasma_d;
  logic [CW-1:0]  sayac_q, sayac_d;
  logic [BIT-1:0] sonuc_q, sonuc_d;
  logic           gecerli_q, gecerli_d;

  logic           isaretli, a_neg, b_neg, sifir, tasma, erken, kabul;
  logic [BIT-1:0] a_mag, b_mag, bolum_son, kalan_son;
  logic [BIT+1:0] deneme, fark;

  assign isaretli = ~islem_i[0];
  assign a_neg    = isaretli & deger1_i[BIT-1];
  assign b_neg    = isaretli & deger2_i[BIT-1];
  assign a_mag    = a_neg ? -deger1_i : deger1_i;
  assign b_mag    = b_neg ? -deger2_i : deger2_i;
  assign sifir    = (deger2_i == '0);
  assign tasma    = isaretli & (deger1_i == {1'b1, {(BIT-1){1'b0}}}) & (&deger2_i);
  assign kabul    = basla_i & ~iptal_i;

`ifdef BOLME_ERKEN_CIKIS_EN
  assign erken = sifir | tasma;
`else
  assign erken = 1'b0;
`endif

  // Trial subtraction on the shifted partial remainder; MSB of the difference is the borrow.
  assign deneme    = {kalan_q, bolum_q[BIT-1]};
  assign fark      = deneme - {2'b00, bolen_q};
  assign bolum_son = neg_b_q ? -bolum_q : bolum_q;
  assign kalan_son = neg_k_q ? -kalan_q[BIT-1:0] : kalan_q[BIT-1:0];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      durum_q   <= BOSTA;
      islem_q   <= '0;
      bolum_q   <= '0;
      kalan_q   <= '0;
      bolen_q   <= '0;
      ham_q     <= '0;
      neg_b_q   <= 1'b0;
      neg_k_q   <= 1'b0;
      sifir_q   <= 1'b0;
      tasma_q   <= 1'b0;
      sayac_q   <= '0;
      sonuc_q   <= '0;
      gecerli_q <= 1'b0;
    end else begin
      durum_q   <= durum_d;
      islem_q   <= islem_d;
      bolum_q   <= bolum_d;
      kalan_q   <= kalan_d;
      bolen_q   <= bolen_d;
      ham_q     <= ham_d;
      neg_b_q   <= neg_b_d;
      neg_k_q   <= neg_k_d;
      sifir_q   <= sifir_d;
      tasma_q   <= tasma_d;
      sayac_q   <= sayac_d;
      sonuc_q   <= sonuc_d;
      gecerli_q <= gecerli_d;
    end
  end

  always_comb begin
    durum_d = durum_q;
    case (durum_q)
      BOSTA:   if (kabul) durum_d = erken ? DUZELT : BOL;
      BOL:     if (sayac_q == CW'(1)) durum_d = DUZELT;
      DUZELT:  durum_d = BOSTA;
      default: durum_d = BOSTA;
    endcase
    if (iptal_i) durum_d = BOSTA;
  end

  always_comb begin
    islem_d   = islem_q;
    bolum_d   = bolum_q;
    kalan_d   = kalan_q;
    bolen_d   = bolen_q;
    ham_d     = ham_q;
    neg_b_d   = neg_b_q;
    neg_k_d   = neg_k_q;
    sifir_d   = sifir_q;
    tasma_d   = tasma_q;
    sayac_d   = sayac_q;
    sonuc_d   = sonuc_q;
    gecerli_d = 1'b0;
    case (durum_q)
      BOSTA: if (kabul) begin
        islem_d = islem_i;
        bolum_d = a_mag;
        kalan_d = '0;
        bolen_d = b_mag;
        ham_d   = deger1_i;
        neg_b_d = a_neg ^ b_neg;
        neg_k_d = a_neg;
        sifir_d = sifir;
        tasma_d = tasma;
        sayac_d = CW'(BIT);
      end
      BOL: if (!iptal_i) begin
        kalan_d = fark[BIT+1] ? deneme[BIT:0] : fark[BIT:0];
        bolum_d = {bolum_q[BIT-2:0], ~fark[BIT+1]};
        sayac_d = sayac_q - CW'(1);
      end
      DUZELT: if (!iptal_i) begin
        gecerli_d = 1'b1;
        if (sifir_q)      sonuc_d = islem_q[1] ? ham_q : '1;
        else if (tasma_q) sonuc_d = islem_q[1] ? '0 : ham_q;
        else              sonuc_d = islem_q[1] ? kalan_son : bolum_son;
      end
      default: ;
    endcase
  end

  assign sonuc_o   = sonuc_q;
  assign gecerli_o = gecerli_q;
  assign mesgul_o  = (durum_q != BOSTA);

endmodule

// File: tb/tb_bolme_birimi.sv
// Scoreboard bench for bolme_birimi: directed vectors, expected results queued at issue time.
module tb_bolme_birimi;

  logic        clk = 1'b0;
  logic        rstn, basla, iptal;
  logic [1:0]  islem;
  logic [31:0] d1, d2, sonuc;
  logic        gecerli, mesgul;
  int          cyc = 0;
  int          total = 0, bad = 0;

`ifdef BOLME_ERKEN_CIKIS_EN
  localparam int LZ = 1;
`else
  localparam int LZ = 33;
`endif

  typedef struct {
    logic [31:0] val;
    int          when;
    string       name;
  } beklenen_t;
  beklenen_t sb[$];

  bolme_birimi #(.BIT(32)) dut (
    .clk_i(clk), .rstn_i(rstn), .basla_i(basla), .islem_i(islem),
    .deger1_i(d1), .deger2_i(d2), .iptal_i(iptal),
    .sonuc_o(sonuc), .gecerli_o(gecerli), .mesgul_o(mesgul)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    beklenen_t e;
    if (rstn === 1'b1 && gecerli === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL stray_valid: got pulse with sonuc=%h at cycle %0d expected none", sonuc, cyc);
      end else begin
        e = sb.pop_front();
        check({e.name, "_value"}, sonuc, e.val);
        check({e.name, "_cycle"}, cyc, e.when);
        check({e.name, "_busy"}, {31'b0, mesgul}, 32'd0);
      end
    end
  end

  // Called one time unit after a rising edge; returns one time unit after the accepting edge.
  task automatic issue(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat, input bit push);
    islem = op; d1 = a; d2 = b; basla = 1'b1;
    @(posedge clk); #1;
    if (push) sb.push_back('{exp, cyc + lat, name});
    basla = 1'b0;
    islem = 2'($urandom);
    d1 = $urandom;
    d2 = $urandom;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL timeout: got %0d results pending expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int k, n;
    rstn = 1'b0; basla = 1'b0; iptal = 1'b0; islem = 2'd0; d1 = '0; d2 = '0;
    #2;
    check("rst_sonuc", sonuc, 32'd0);
    check("rst_gecerli", {31'b0, gecerli}, 32'd0);
    check("rst_mesgul", {31'b0, mesgul}, 32'd0);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;

    issue("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 33, 1'b1);
    check("busy_after_accept", {31'b0, mesgul}, 32'd1);
    wait_done();
    issue("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 33, 1'b1); wait_done();
    issue("div_m7_2",   2'b00, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 1'b1); wait_done();
    issue("rem_m7_2",   2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, 1'b1); wait_done();
    issue("div_100_m7", 2'b00, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 33, 1'b1); wait_done();
    issue("rem_100_m7", 2'b10, 32'd100, 32'hFFFFFFF9, 32'd2, 33, 1'b1); wait_done();
    issue("div_ovf",    2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, LZ, 1'b1); wait_done();
    issue("rem_ovf",    2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, LZ, 1'b1); wait_done();
    issue("divu_big",   2'b01, 32'h80000000, 32'hFFFFFFFF, 32'd0, 33, 1'b1); wait_done();
    issue("remu_big",   2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33, 1'b1); wait_done();
    issue("divu_5_0",   2'b01, 32'd5, 32'd0, 32'hFFFFFFFF, LZ, 1'b1); wait_done();
    issue("remu_5_0",   2'b11, 32'd5, 32'd0, 32'd5, LZ, 1'b1); wait_done();
    issue("div_m5_0",   2'b00, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, LZ, 1'b1); wait_done();
    issue("rem_m5_0",   2'b10, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, LZ, 1'b1); wait_done();

    // Flush at k+10, restart at k+11.
    issue("div_flushed", 2'b00, 32'd1000, 32'd3, 32'd0, 0, 1'b0);
    k = cyc;
    while (cyc < k + 9) begin @(posedge clk); #1; end
    iptal = 1'b1;
    @(posedge clk); #1;
    iptal = 1'b0;
    check("iptal_busy", {31'b0, mesgul}, 32'd0);
    check("iptal_gecerli", {31'b0, gecerli}, 32'd0);
    check("iptal_hold", sonuc, 32'hFFFFFFFB);
    issue("after_iptal", 2'b00, 32'd1000, 32'd3, 32'd333, 33, 1'b1); wait_done();

    // Flush wins over a simultaneous start.
    iptal = 1'b1; islem = 2'b01; d1 = 32'd8; d2 = 32'd2; basla = 1'b1;
    @(posedge clk); #1;
    iptal = 1'b0; basla = 1'b0;
    check("iptal_prio_busy", {31'b0, mesgul}, 32'd0);

    // Start request while busy is dropped.
    issue("divu_ign", 2'b01, 32'd100, 32'd7, 32'd14, 33, 1'b1);
    k = cyc;
    while (cyc < k + 4) begin @(posedge clk); #1; end
    islem = 2'b01; d1 = 32'd9; d2 = 32'd3; basla = 1'b1;
    @(posedge clk); #1;
    basla = 1'b0;
    check("ign_busy", {31'b0, mesgul}, 32'd1);
    wait_done();

    // Back-to-back: new start during the valid cycle.
    issue("b2b_first", 2'b01, 32'd1000, 32'd10, 32'd100, 33, 1'b1);
    n = 0;
    while (gecerli !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    if (gecerli !== 1'b1) begin
      total++; bad++;
      $display("FAIL b2b_wait: got no valid expected pulse");
    end
    issue("b2b_second", 2'b11, 32'd1000, 32'd7, 32'd6, 33, 1'b1);
    wait_done();

    // Reset in the middle of iteration.
    issue("div_reset", 2'b00, 32'd1000, 32'd3, 32'd0, 0, 1'b0);
    repeat (10) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    check("midrst_sonuc", sonuc, 32'd0);
    check("midrst_gecerli", {31'b0, gecerli}, 32'd0);
    check("midrst_mesgul", {31'b0, mesgul}, 32'd0);
    @(negedge clk); rstn = 1'b1;
    issue("after_rst", 2'b01, 32'd100, 32'd7, 32'd14, 33, 1'b1); wait_done();

    repeat (40) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
